// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the multicycle main FSM and the shared-memory
// datapath.
//
// Signals:
//   opcode    : instr[31:26] from the instruction register
//   mem_ready : memory access completes this cycle
//   iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
//   alusrcb, aluop, pcsrc, pcwrite, branch, branch_ne : datapath controls
//   illegal_op: unsupported opcode seen in DECODE
//   state     : current FSM state, for debug
//
// Modports:
//   master : the controller (drives the controls, reads opcode/mem_ready)
//   slave  : the datapath side
interface multicycle_main_fsm_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         opcode;
  logic               mem_ready;
  logic               iord;
  logic               memwrite;
  logic               irwrite;
  logic               regdst;
  logic               memtoreg;
  logic               regwrite;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic [1:0]         aluop;
  logic [1:0]         pcsrc;
  logic               pcwrite;
  logic               branch;
  logic               branch_ne;
  logic               illegal_op;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode, mem_ready,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, aluop, pcsrc, pcwrite, branch, branch_ne, illegal_op,
           state
  );

  modport slave (
    output opcode, mem_ready,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, aluop, pcsrc, pcwrite, branch, branch_ne, illegal_op,
           state
  );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Multicycle MIPS main controller FSM.
//
// Sequences each instruction through FETCH, DECODE, execute, memory and
// writeback states, driving datapath selects and write enables. Memory
// accesses in FETCH, MEMREAD and MEMWRITE stall until mem_ready.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; returns the FSM to FETCH
//   bus   : multicycle_main_fsm_if.master (opcode, mem_ready in; all
//           datapath controls, illegal_op and debug state out)
//
// Parameters:
//   USE_MEM_READY : 1 = honour mem_ready, 0 = treat it as always 1
//   STATE_W       : state register width (4 or more)
//
// Build option:
//   MULTICYCLE_BNE_EN : adds the BNE state (opcode 000101, encoding 12)
//                       and drives branch_ne; otherwise bne is illegal
//                       and branch_ne is tied 0.
module multicycle_main_fsm #(
  parameter int USE_MEM_READY = 1,
  parameter int STATE_W       = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_main_fsm_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEMADR   = STATE_W'(2),
    S_MEMREAD  = STATE_W'(3),
    S_MEMWB    = STATE_W'(4),
    S_MEMWRITE = STATE_W'(5),
    S_EXECUTE  = STATE_W'(6),
    S_ALUWB    = STATE_W'(7),
    S_BRANCH   = STATE_W'(8),
    S_IMMEXEC  = STATE_W'(9),
    S_IMMWB    = STATE_W'(10),
    S_JUMP     = STATE_W'(11),
    S_BNE      = STATE_W'(12)
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Moore portion of the outputs. irwrite and the FETCH pcwrite are not
  // stored here because they follow mem_ready combinationally.
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
`ifdef MULTICYCLE_BNE_EN
    logic       branch_ne;
`endif
  } ctrl_t;

  state_e state_q;
  state_e state_nxt;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_out;
  logic   mem_ok;
  logic   fetch_go;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
      OP_LW, OP_SW: is_legal = 1'b1;
`ifdef MULTICYCLE_BNE_EN
      OP_BNE:       is_legal = 1'b1;
`endif
      default:      is_legal = 1'b0;
    endcase
  endfunction

  function automatic state_e next_state(input state_e s, input logic [5:0] op,
                                        input logic ok);
    next_state = S_FETCH;
    case (s)
      S_FETCH:    next_state = ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                     next_state = S_MEMADR;
          OP_RTYPE:                         next_state = S_EXECUTE;
          OP_BEQ:                           next_state = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = S_IMMEXEC;
          OP_J:                             next_state = S_JUMP;
`ifdef MULTICYCLE_BNE_EN
          OP_BNE:                           next_state = S_BNE;
`endif
          default:                          next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_state = ok ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: next_state = ok ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  next_state = S_ALUWB;
      S_IMMEXEC:  next_state = S_IMMWB;
      default:    next_state = S_FETCH;
    endcase
  endfunction

  function automatic ctrl_t decode(input state_e s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    c.alusrcb = 2'b01;
      S_DECODE:   c.alusrcb = 2'b11;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMREAD:  c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b11;
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b01;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      S_IMMEXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        // addi uses the plain add; the logical/compare immediates are
        // resolved by the ALU decoder from the opcode.
        c.aluop   = (op == OP_ADDI) ? 2'b00 : 2'b10;
      end
      S_IMMWB:    c.regwrite = 1'b1;
      S_JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
`ifdef MULTICYCLE_BNE_EN
      S_BNE: begin
        c.alusrca   = 1'b1;
        c.aluop     = 2'b01;
        c.pcsrc     = 2'b01;
        c.branch_ne = 1'b1;
      end
`endif
      default:    c = '0;
    endcase
    return c;
  endfunction

  assign mem_ok = (USE_MEM_READY != 0) ? bus.mem_ready : 1'b1;

  always_comb begin
    state_nxt = next_state(state_q, bus.opcode, mem_ok);
  end

  // Outputs are registered from the next-state decode, so they line up
  // with the state register. The opcode is stable in the instruction
  // register from DECODE, so IMMEXEC's aluop can be resolved on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode(S_FETCH, 6'd0);
    end else begin
      state_q <= state_nxt;
      ctrl_q  <= decode(state_nxt, bus.opcode);
    end
  end

  // While reset is high the outputs must already look like FETCH, even
  // before the first edge, so no stale memwrite/regwrite can escape.
  assign ctrl_out = reset ? decode(S_FETCH, 6'd0) : ctrl_q;
  assign fetch_go = (state_q == S_FETCH) && mem_ok && !reset;

  assign bus.iord       = ctrl_out.iord;
  assign bus.memwrite   = ctrl_out.memwrite;
  assign bus.irwrite    = fetch_go;
  assign bus.regdst     = ctrl_out.regdst;
  assign bus.memtoreg   = ctrl_out.memtoreg;
  assign bus.regwrite   = ctrl_out.regwrite;
  assign bus.alusrca    = ctrl_out.alusrca;
  assign bus.alusrcb    = ctrl_out.alusrcb;
  assign bus.aluop      = ctrl_out.aluop;
  assign bus.pcsrc      = ctrl_out.pcsrc;
  assign bus.pcwrite    = ctrl_out.pcwrite | fetch_go;
  assign bus.branch     = ctrl_out.branch;
`ifdef MULTICYCLE_BNE_EN
  assign bus.branch_ne  = ctrl_out.branch_ne;
`else
  assign bus.branch_ne  = 1'b0;
`endif
  assign bus.illegal_op = (state_q == S_DECODE) && !is_legal(bus.opcode) && !reset;
  assign bus.state      = state_q;

endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
- Multicycle successor to the single-cycle main decoder.
- Sequences each MIPS instruction through fetch, decode, execute, memory and writeback states. Drives the datapath mux selects and write enables one state per cycle.
- Adds a memory wait handshake, so memory can stall any access state.
- Sits in the controller beside the ALU decoder. Takes the opcode from the instruction register and feeds enables to the shared-memory multicycle datapath.

Parameters:
- USE_MEM_READY, 1: 1 = honour mem_ready; 0 = mem_ready is ignored and treated as constant 1.
- STATE_W, 4: width of the state register and of the state debug output; must be 4 or more.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- opcode  in  6  instr[31:26] from the instruction register; valid from DECODE onward.
- mem_ready  in  1  memory access completes this cycle.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  memory write enable.
- irwrite  out  1  instruction register load.
- regdst  out  1  write-register select: 1 = rd, 0 = rt.
- memtoreg  out  1  writeback select: 1 = memory data, 0 = ALUOut.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = signext immediate, 11 = signext immediate << 2.
- aluop  out  2  00 = add, 01 = subtract, 11 = R-type funct, 10 = immediate op decoded from opcode.
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- pcwrite  out  1  unconditional PC write.
- branch  out  1  PC write if ALU zero.
- branch_ne  out  1  PC write if ALU not zero; tied 0 without the optional feature.
- illegal_op  out  1  unsupported opcode detected in DECODE.
- state  out  STATE_W  current state encoding, for debug.

Behaviour:
- Registered state, Moore outputs decoded from state. Exceptions: irwrite, pcwrite and the state exits also depend on mem_ready; illegal_op depends on opcode.
- Any output not listed for a state is 0.
- Reset: state <= FETCH (0) on the clock edge where reset is high, from any state including mid-instruction. While reset is high, outputs are the FETCH decode with irwrite and pcwrite forced to 0. No memory write can occur while reset is high.
- Encodings and per-state outputs:
  - 0 FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=pcwrite=mem_ready. Holds until mem_ready=1, then goes to DECODE.
  - 1 DECODE: alusrca=0, alusrcb=11, aluop=00. Next state:
    - lw 100011 / sw 101011 -> MEMADR
    - R-type 000000 -> EXECUTE
    - beq 000100 -> BRANCH
    - addi 001000, andi 001100, ori 001101, slti 001010 -> IMMEXEC
    - j 000010 -> JUMP
    - any other opcode -> FETCH, with illegal_op=1 for this single cycle.
  - 2 MEMADR: alusrca=1, alusrcb=10, aluop=00. lw -> MEMREAD; sw -> MEMWRITE.
  - 3 MEMREAD: iord=1. Holds until mem_ready, then -> MEMWB.
  - 4 MEMWB: regdst=0, memtoreg=1, regwrite=1. -> FETCH.
  - 5 MEMWRITE: iord=1, memwrite=1, held for every wait cycle. Exits on mem_ready -> FETCH.
  - 6 EXECUTE: alusrca=1, alusrcb=00, aluop=11. -> ALUWB.
  - 7 ALUWB: regdst=1, memtoreg=0, regwrite=1. -> FETCH.
  - 8 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. -> FETCH.
  - 9 IMMEXEC: alusrca=1, alusrcb=10; aluop=00 for addi, 10 for andi/ori/slti. -> IMMWB.
  - 10 IMMWB: regdst=0, memtoreg=0, regwrite=1. -> FETCH.
  - 11 JUMP: pcsrc=10, pcwrite=1. -> FETCH.
- Unused encodings 12-15 go to FETCH next cycle with all outputs 0.
- Latency with zero wait states, fetch to fetch:
  - lw: 5 cycles
  - sw, R-type, immediate: 4 cycles
  - beq, j: 3 cycles
  - illegal opcode: 2 cycles
- Each wait cycle adds one cycle to FETCH, MEMREAD or MEMWRITE.
- regwrite and memwrite are never both 1. irwrite is 1 only in FETCH.

Optional Feature:
- Macro MULTICYCLE_BNE_EN.
- When defined: opcode 000101 (bne) in DECODE goes to state 12 BNE.
  - BNE outputs: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch_ne=1. -> FETCH.
  - Encoding 12 is then valid and excluded from the unused-encoding rule.
- When undefined: 000101 is illegal (illegal_op pulse, DECODE -> FETCH), and branch_ne is constant 0.

Test Plan:
- Reset held 2 cycles, mem_ready=1 -> state=0, irwrite=0, pcwrite=0, memwrite=0. After release, irwrite=pcwrite=1 and state goes 0 -> 1.
- lw (100011) with mem_ready low 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0. regwrite=1 and memtoreg=1 only in state 4. Total 7 cycles.
- sw (101011) with mem_ready low 1 cycle -> memwrite=1 for 2 consecutive cycles in state 5. regwrite stays 0 throughout.
- R-type, then ori (001101), then addi (001000) -> aluop=11 in state 6. aluop=10 in state 9 for ori, aluop=00 in state 9 for addi. regdst=1 in state 7, 0 in state 10.
- beq (000100) and j (000010) -> beq: state 8 with branch=1, aluop=01, pcsrc=01. j: state 11 with pcwrite=1, pcsrc=10. Each 3 cycles.
- opcode 111111, then reset asserted while in state 3 -> illegal_op=1 for one cycle in DECODE, then FETCH. Reset mid-lw gives state=0 next edge with no regwrite. With MULTICYCLE_BNE_EN, opcode 000101 -> state 12, branch_ne=1.
